// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared combinational alu: two valid/ready operand ports,
// one registered operand pair to the alu, one registered and id-tagged response port.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N-1:0] r0_x,
    input  logic [N-1:0] r0_y,

    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N-1:0] r1_x,
    input  logic [N-1:0] r1_y,

    output logic [N-1:0] alu_x,
    output logic [N-1:0] alu_y,
    input  logic [N-1:0] alu_z,
    input  logic         alu_zf,
    input  logic         alu_sf,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_z,
    output logic         rsp_zf,
    output logic         rsp_sf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state_q,     state_d;
    logic         last_q,      last_d;
    logic         gid_q,       gid_d;
    logic [N-1:0] op_x_q,      op_x_d;
    logic [N-1:0] op_y_q,      op_y_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q,    rsp_id_d;
    logic [N-1:0] rsp_z_q,     rsp_z_d;
    logic         rsp_zf_q,    rsp_zf_d;
    logic         rsp_sf_q,    rsp_sf_d;

    logic any_valid;
    logic gnt_id;
    logic accept;

    // With both requesters pending the one not served last wins; otherwise the lone one.
    assign any_valid = r0_valid | r1_valid;
    assign gnt_id    = (r0_valid & r1_valid) ? ~last_q : r1_valid;
    assign accept    = (state_q == IDLE) & any_valid & ~rst;

    assign r0_ready  = accept & ~gnt_id;
    assign r1_ready  = accept &  gnt_id;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gid_d       = gid_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        rsp_zf_d    = rsp_zf_q;
        rsp_sf_d    = rsp_sf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_x_d  = gnt_id ? r1_x : r0_x;
                    op_y_d  = gnt_id ? r1_y : r0_y;
                    gid_d   = gnt_id;
                    last_d  = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_z_d     = alu_z;
                rsp_zf_d    = alu_zf;
                rsp_sf_d    = alu_sf;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gid_q       <= 1'b0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_z_q     <= '0;
            rsp_zf_q    <= 1'b0;
            rsp_sf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gid_q       <= gid_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            rsp_zf_q    <= rsp_zf_d;
            rsp_sf_q    <= rsp_sf_d;
        end
    end

    // The alu sees the operand registers continuously, not only during EXEC.
    assign alu_x     = op_x_q;
    assign alu_y     = op_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_sf    = rsp_sf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an adder stub as the shared alu.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
    logic [31:0] alu_x, alu_y, alu_z;
    logic        alu_zf, alu_sf;
    logic        rsp_valid, rsp_id, rsp_zf, rsp_sf;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_z;

    typedef struct packed {
        logic        id;
        logic [31:0] z;
        logic        zf;
        logic        sf;
    } exp_t;

    exp_t exp_q[$];
    bit   grant_log[$];
    int   checks = 0;
    int   passes = 0;
    int   n_rsp  = 0;

    always #5 clk = ~clk;

    assign alu_z  = alu_x + alu_y;
    assign alu_zf = (alu_z == 32'h0);
    assign alu_sf = alu_z[31];

    alu_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z), .alu_zf(alu_zf), .alu_sf(alu_sf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every response handshake must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got id=%0d z=%h, expected no response", rsp_id, rsp_z);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id === e.id && rsp_z === e.z && rsp_zf === e.zf && rsp_sf === e.sf) begin
                        passes++;
                        $display("rsp id=%0d z=%h zf=%b sf=%b ok", rsp_id, rsp_z, rsp_zf, rsp_sf);
                    end else begin
                        $display("FAIL rsp: got id=%0d z=%h zf=%b sf=%b expected id=%0d z=%h zf=%b sf=%b",
                                 rsp_id, rsp_z, rsp_zf, rsp_sf, e.id, e.z, e.zf, e.sf);
                    end
                end
            end
        end
    end

    task automatic drive(input bit id, input logic v, input logic [31:0] x, input logic [31:0] y);
        if (!id) begin r0_valid = v; r0_x = x; r0_y = y; end
        else     begin r1_valid = v; r1_x = x; r1_y = y; end
    endtask

    // Issue one operation; valid stays high afterwards unless last_op.
    task automatic req(input bit id, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ez, input bit ezf, input bit esf, input bit last_op);
        bit got = 1'b0;
        exp_t e;
        drive(id, 1'b1, x, y);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (id ? r1_ready : r0_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL grant_timeout: requester %0d got no ready, expected ready within 50 cycles", id);
            drive(id, 1'b0, x, y);
            return;
        end
        grant_log.push_back(id);
        e.id = id; e.z = ez; e.zf = ezf; e.sf = esf;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (last_op) drive(id, 1'b0, x, y);
        @(negedge clk);
        check("exec_no_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        @(negedge clk);
        check("rsp_latency", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_r0_ready", {31'd0, r0_ready}, 32'd0);
        check("reset_r1_ready", {31'd0, r1_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_alu_x", alu_x, 32'd0);
        check("reset_alu_y", alu_y, 32'd0);

        // Single request and flag cases
        @(posedge clk); #1 rsp_ready = 1'b1;
        req(1'b0, 32'h112233ff, 32'h1, 32'h11223400, 1'b0, 1'b0, 1'b1);
        req(1'b1, 32'hffffffff, 32'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        req(1'b1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b0, 1'b1, 1'b1);

        // Contention: grants must alternate starting with requester 0
        repeat (2) @(posedge clk);
        #1 grant_log.delete();
        fork
            begin
                req(1'b0, 32'h5, 32'h7, 32'hc, 1'b0, 1'b0, 1'b0);
                req(1'b0, 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b1, 1'b1);
            end
            begin
                req(1'b1, 32'h100, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0);
                req(1'b1, 32'h7fffffff, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b1);
            end
        join
        check("grant_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("grant_order[%0d]", i), {31'd0, grant_log[i]}, i % 2);

        // Backpressure: response held, no new accept while it waits
        @(posedge clk); #1 rsp_ready = 1'b0;
        req(1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h1, 32'hfffffffe);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_z", rsp_z, 32'h30);
            check("bp_no_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        req(1'b1, 32'h1, 32'hfffffffe, 32'hffffffff, 1'b0, 1'b1, 1'b1);

        // Reset during EXEC drops the in-flight result and restores priority to requester 0
        repeat (2) @(posedge clk);
        #1 drive(1'b1, 1'b1, 32'h3, 32'h4);
        begin
            bit got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                if (r1_ready) got = 1'b1;
            end
            check("midrst_grant", {31'd0, got}, 32'd1);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h3, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_alu_x", alu_x, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 32'h9, 32'h9);
        @(negedge clk);
        check("postrst_first_grant", {30'd0, r0_ready, r1_ready}, 32'd2);
        if (r0_ready) begin
            e.id = 1'b0; e.z = 32'h0; e.zf = 1'b1; e.sf = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 32'h9, 32'h9);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        check("rsp_count", n_rsp, 32'd10);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
